// File: rtl/dgd_tt_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package dgd_tt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        CHECK,
        DONE
    } tt_state_e;

    localparam logic [15:0] TT_1858 = 16'h1858;

    // Truth-table width for a gate with n_in inputs.
    function automatic int unsigned tt_width(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle timer: load arms a countdown, expire is high on the last enabled cycle of the settle window.
module tt_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [7:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= 8'(SETTLE_CYCLES - 1);
        end else if (en && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign expire = en && (cnt == 8'd0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps every input vector of one combinational gate, captures its truth table
// and compares it against a golden table.
module tt_sweep_ctrl
    import dgd_tt_pkg::*;
#(
    parameter int unsigned                     N_IN          = 4,
    parameter logic [tt_width(N_IN)-1:0]       EXPECTED_TT   = TT_1858,
    parameter int unsigned                     SETTLE_CYCLES = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  abort,
    output logic [N_IN-1:0]                       gate_in,
    input  logic                                  gate_out,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  pass,
    output logic [tt_width(N_IN)-1:0]             captured_tt,
    output logic [tt_width(N_IN)-1:0]             mismatch_mask,
    output logic [$clog2(tt_width(N_IN)+1)-1:0]   fail_count,
    output logic [N_IN-1:0]                       first_fail_idx
);

    localparam int unsigned     TT_W     = tt_width(N_IN);
    localparam int unsigned     FC_W     = $clog2(TT_W + 1);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TT_W - 1);

    tt_state_e         state;
    logic [N_IN-1:0]   idx;
    logic [TT_W-1:0]   shadow;
    logic              timer_load;
    logic              timer_expire;
    logic [TT_W-1:0]   chk_mask;
    logic [FC_W-1:0]   chk_count;
    logic [N_IN-1:0]   chk_first;

    assign gate_in = idx;

    // Arm the settle window on every entry into DRIVE.
    assign timer_load = !abort &&
                        ((state == IDLE && start) || (state == SAMPLE && idx != LAST_IDX));

    tt_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .en     (state == DRIVE),
        .expire (timer_expire)
    );

    // Sweep index i lands in TT bit TT_W-1-i, so the lowest failing index is the highest set mask bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        chk_mask  = shadow ^ EXPECTED_TT;
        chk_count = '0;
        chk_first = '0;
        for (int i = int'(TT_W) - 1; i >= 0; i--) begin
            chk_count = chk_count + FC_W'(chk_mask[i]);
            if (chk_mask[int'(TT_W) - 1 - i]) begin
                chk_first = N_IN'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            shadow         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            captured_tt    <= '0;
            mismatch_mask  <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                idx   <= '0;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state  <= DRIVE;
                            idx    <= '0;
                            shadow <= '0;
                            busy   <= 1'b1;
                        end
                    end
                    DRIVE: begin
                        if (timer_expire) begin
                            state <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        // Shifting in keeps index 0 at the MSB once all vectors are in.
                        shadow <= {shadow[TT_W-2:0], gate_out};
                        if (idx == LAST_IDX) begin
                            state <= CHECK;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= DRIVE;
                        end
                    end
                    CHECK: begin
                        captured_tt    <= shadow;
                        mismatch_mask  <= chk_mask;
                        fail_count     <= chk_count;
                        first_fail_idx <= chk_first;
                        pass           <= (chk_mask == '0);
                        done           <= 1'b1;
                        state          <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: default build plus a SETTLE_CYCLES=1 build, with a
// table-driven gate model, directed corner sequences and randomized tables.
module tb_tt_sweep_ctrl;
    import dgd_tt_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, start_b, abort;
    logic [15:0] gate_tt;

    logic [3:0]  gin_a, gin_b, ff_a, ff_b;
    logic        gout_a, gout_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [15:0] cap_a, cap_b, mask_a, mask_b;
    logic [4:0]  fc_a, fc_b;

    // Gate under test: a truth-table lookup, input vector 0 is the table MSB.
    assign gout_a = gate_tt[4'd15 - gin_a];
    assign gout_b = gate_tt[4'd15 - gin_b];

    tt_sweep_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort),
        .gate_in(gin_a), .gate_out(gout_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .captured_tt(cap_a), .mismatch_mask(mask_a),
        .fail_count(fc_a), .first_fail_idx(ff_a)
    );

    tt_sweep_ctrl #(.SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort),
        .gate_in(gin_b), .gate_out(gout_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .captured_tt(cap_b), .mismatch_mask(mask_b),
        .fail_count(fc_b), .first_fail_idx(ff_b)
    );

    typedef struct {
        logic [15:0] cap;
        logic [15:0] mask;
        logic [4:0]  fc;
        logic [3:0]  ff;
        logic        pass;
        int          lat;
    } res_t;

    typedef struct {
        bit          sel;
        logic [15:0] tt;
        res_t        exp;
    } vec_t;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: the captured table is the gate's table; everything else follows from the golden table.
    function automatic res_t model(input logic [15:0] tt, input int settle);
        res_t r;
        r.cap  = tt;
        r.mask = tt ^ TT_1858;
        r.fc   = 5'($countones(r.mask));
        r.ff   = 4'd0;
        for (int v = 15; v >= 0; v--) begin
            if (r.mask[15 - v]) r.ff = 4'(v);
        end
        r.pass = (r.mask == 16'h0);
        r.lat  = 16 * (settle + 1) + 2;
        return r;
    endfunction

    // One full sweep from a start pulse; latency is counted in cycles after the start cycle.
    task automatic sweep(input bit sel, input logic [15:0] tt, output res_t r);
        gate_tt = tt;
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        r.lat = -1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            if ((sel ? done_b : done_a) === 1'b1) begin
                r.lat = c;
                break;
            end
        end
        r.cap  = sel ? cap_b  : cap_a;
        r.mask = sel ? mask_b : mask_a;
        r.fc   = sel ? fc_b   : fc_a;
        r.ff   = sel ? ff_b   : ff_a;
        r.pass = sel ? pass_b : pass_a;
        @(negedge clk);
        check("done_one_cycle", sel ? done_b : done_a, 1'b0);
        check("idle_after_done", sel ? busy_b : busy_a, 1'b0);
    endtask

    task automatic compare(input string tag, input res_t act, input res_t exp);
        check({tag, "_latency"}, act.lat, exp.lat);
        check({tag, "_captured"}, act.cap, exp.cap);
        check({tag, "_mask"}, act.mask, exp.mask);
        check({tag, "_fail_count"}, act.fc, exp.fc);
        check({tag, "_first_fail"}, act.ff, exp.ff);
        check({tag, "_pass"}, act.pass, exp.pass);
    endtask

    vec_t tbl[7];
    res_t res;
    res_t exp_r;
    int   done_cnt;
    int   done_at0;
    int   done_at1;
    bit   hit;

    initial begin
        tbl[0] = '{0, 16'h1858, '{16'h1858, 16'h0000, 5'd0,  4'd0,  1'b1, 66}};
        tbl[1] = '{0, 16'h0000, '{16'h0000, 16'h1858, 5'd5,  4'd3,  1'b0, 66}};
        tbl[2] = '{0, 16'hFFFF, '{16'hFFFF, 16'hE7A7, 5'd11, 4'd0,  1'b0, 66}};
        tbl[3] = '{0, 16'h1859, '{16'h1859, 16'h0001, 5'd1,  4'd15, 1'b0, 66}};
        tbl[4] = '{0, 16'h9858, '{16'h9858, 16'h8000, 5'd1,  4'd0,  1'b0, 66}};
        tbl[5] = '{0, 16'h1848, '{16'h1848, 16'h0010, 5'd1,  4'd11, 1'b0, 66}};
        tbl[6] = '{1, 16'hE7A7, '{16'hE7A7, 16'hFFFF, 5'd16, 4'd0,  1'b0, 34}};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; gate_tt = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_pass", pass_a, 1'b0);
        check("rst_gate_in", gin_a, 4'd0);
        check("rst_captured", cap_a, 16'h0);
        check("rst_mask", mask_a, 16'h0);
        check("rst_fail_count", fc_a, 5'd0);
        check("rst_first_fail", ff_a, 4'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            sweep(tbl[i].sel, tbl[i].tt, res);
            compare($sformatf("tbl%0d", i), res, tbl[i].exp);
        end

        // Abort a second sweep while vector 7 is driven; the first run's results must survive.
        sweep(0, 16'h1858, res);
        compare("pre_abort", res, model(16'h1858, 3));
        @(negedge clk);
        start_a = 1'b1;
        hit = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (gin_a == 4'd7) begin
                hit = 1'b1;
                break;
            end
        end
        check("abort_reach_idx7", hit, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy_a, 1'b0);
        check("abort_gate_in", gin_a, 4'd0);
        check("abort_done", done_a, 1'b0);
        done_cnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (done_a) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_keep_pass", pass_a, 1'b1);
        check("abort_keep_captured", cap_a, 16'h1858);

        // Reset during SAMPLE of index 10 (cycle 44 after the start cycle).
        gate_tt = 16'h0000;
        @(negedge clk);
        start_a = 1'b1;
        for (int c = 1; c <= 44; c++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        check("rst_mid_gate_in", gin_a, 4'd10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", busy_a, 1'b0);
        check("rst_mid_gate_in0", gin_a, 4'd0);
        check("rst_mid_pass", pass_a, 1'b0);
        check("rst_mid_captured", cap_a, 16'h0);
        check("rst_mid_mask", mask_a, 16'h0);
        check("rst_mid_fail_count", fc_a, 5'd0);
        check("rst_mid_first_fail", ff_a, 4'd0);
        sweep(0, 16'h0000, res);
        compare("post_rst", res, model(16'h0000, 3));

        // Stray start mid-run is ignored; start held through DONE restarts on the first IDLE cycle.
        gate_tt  = 16'h1858;
        done_cnt = 0;
        done_at0 = -1;
        done_at1 = -1;
        @(negedge clk);
        start_a = 1'b1;
        for (int c = 1; c <= 140; c++) begin
            @(negedge clk);
            start_a = (c == 20) || (c >= 60 && c <= 67);
            if (done_a) begin
                done_cnt++;
                if (done_at0 < 0) done_at0 = c; else done_at1 = c;
            end
            if (c == 67) check("restart_idle_gap", busy_a, 1'b0);
            if (c == 68) check("restart_busy", busy_a, 1'b1);
        end
        start_a = 1'b0;
        check("restart_done_count", done_cnt, 2);
        check("restart_first_done", done_at0, 66);
        check("restart_second_done", done_at1, 133);
        check("restart_pass", pass_a, 1'b1);

        // Randomized gate tables against the reference model, on both builds.
        for (int n = 0; n < 12; n++) begin
            bit sel;
            logic [15:0] tt;
            sel = (n >= 8);
            tt  = 16'($urandom);
            if (n == 3) tt = TT_1858 ^ (16'h1 << $urandom_range(0, 15));
            exp_r = model(tt, sel ? 1 : 3);
            sweep(sel, tt, res);
            compare($sformatf("rand%0d", n), res, exp_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
